mx_blk_quant_seq: RTL and testbench

// - Sequences one MX block quantisation: buffers K signed integer elements, derives the shared block exponent,

---
 rtl/mx_blk_quant_seq_pkg.sv | 31 +++
 rtl/mx_blk_quant_seq_rnd.sv | 82 ++++++++
 rtl/mx_blk_quant_seq.sv | 170 +++++++++++++++++
 tb/tb_mx_blk_quant_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mx_blk_quant_seq_pkg.sv
// Shared types and helpers for the MX block quantisation sequencer.
package mx_blk_quant_seq_pkg;

  // Default block length and the matching element counter width.
  // The counter has one extra bit so it can count up to and including K.
  localparam int BLK_K     = 32;
  localparam int DEF_CNT_W = $clog2(BLK_K) + 1;

  // Sequencer states: collect a block, derive its exponent, stream it out.
  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SCALE = 2'd1,
    ST_EMIT  = 2'd2
  } state_e;

  // Counter width for a block of k elements.
  function automatic int cnt_width(input int k);
    return $clog2(k) + 1;
  endfunction

  // Bit index of the most significant set bit, or -1 for an all-zero word.
  function automatic int lzd_pos(input logic [31:0] v);
    int pos;
    pos = -1;
    for (int b = 0; b < 32; b++) begin
      if (v[b]) pos = b;
    end
    return pos;
  endfunction

endpackage

// File: rtl/mx_blk_quant_seq_rnd.sv
// Round-to-nearest-even conversion of an unsigned magnitude, scaled down by
// 2^i_shift, into a small minifloat exponent/mantissa code pair.
// Subnormals are supported; results above the largest finite value saturate.
module fp_rnd_rne
  import mx_blk_quant_seq_pkg::*;
#(
  parameter int width_i     = 8,
  parameter int width_shift = 8,
  parameter int width_o_exp = 2,
  parameter int width_o_man = 1,
  parameter int EMAX_ELEM   = 2
) (
  input  logic [width_i-1:0]     i_num,
  input  logic [width_shift-1:0] i_shift,
  output logic [width_o_exp-1:0] o_exp,
  output logic [width_o_man-1:0] o_man
);

  localparam int Bias = (1 << (width_o_exp - 1)) - 1;
  localparam int EMin = 1 - Bias;
  localparam int MW   = width_i + width_o_man + 3;
  localparam int RMax = width_i + 1;

  logic [MW-1:0] mag;
  logic [MW-1:0] quot;
  logic [MW-1:0] rem;
  logic [MW-1:0] half;
  logic          up;
  int            lead;
  int            e;
  int            ee;
  int            r;

  // Pick the quantum for the value's binade (or the subnormal quantum), divide
  // the magnitude by it with RNE, renormalise on carry-out, then encode.
  // A quantum shift beyond the input width behaves exactly like width+1 since
  // the magnitude is then strictly below half a quantum.
  always_comb begin
    o_exp = '0;
    o_man = '0;
    mag   = MW'(i_num);
    quot  = '0;
    rem   = '0;
    half  = '0;
    up    = 1'b0;
    lead  = 0;
    e     = 0;
    ee    = 0;
    r     = 0;
    if (i_num != '0) begin
      lead = lzd_pos(32'(i_num));
      e    = lead - int'(i_shift);
      ee   = (e < EMin) ? EMin : e;
      r    = ee - width_o_man + int'(i_shift);
      if (r <= 0) begin
        quot = mag << (-r);
      end else begin
        if (r > RMax) r = RMax;
        quot = mag >> r;
        rem  = mag & ((MW'(1) << r) - MW'(1));
        half = MW'(1) << (r - 1);
        up   = (rem > half) || ((rem == half) && quot[0]);
      end
      quot = quot + MW'(up);
      if (quot >= (MW'(1) << (width_o_man + 1))) begin
        quot = quot >> 1;
        ee   = ee + 1;
      end
      if (quot < (MW'(1) << width_o_man)) begin
        o_exp = '0;
        o_man = quot[width_o_man-1:0];
      end else if (ee > EMAX_ELEM) begin
        o_exp = '1;
        o_man = '1;
      end else begin
        o_exp = width_o_exp'(ee + Bias);
        o_man = quot[width_o_man-1:0];
      end
    end
  end

endmodule

// File: rtl/mx_blk_quant_seq.sv
// MX block quantisation sequencer: buffers K signed elements, derives the
// shared block exponent from the largest magnitude, then streams every element
// through a single RNE rounder into registered sign/exp/man outputs.
module mx_blk_quant_seq
  import mx_blk_quant_seq_pkg::*;
#(
  parameter int K           = BLK_K,
  parameter int width_i     = 8,
  parameter int width_o_exp = 2,
  parameter int width_o_man = 1,
  parameter int width_shift = 8,
  parameter int EMAX_ELEM   = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [width_i-1:0]     i_num,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_sign,
  output logic [width_o_exp-1:0] o_exp,
  output logic [width_o_man-1:0] o_man,
  output logic [width_shift-1:0] o_scale,
  output logic                   o_last
);

  localparam int CntW = cnt_width(K);
  localparam int IdxW = CntW - 1;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [width_i-1:0]     maxAbs_q, maxAbs_d;
  logic [width_shift-1:0] scale_q, scale_d;
  logic                   valid_q, valid_d;
  logic                   sign_q, sign_d;
  logic                   last_q, last_d;
  logic [width_o_exp-1:0] exp_q, exp_d;
  logic [width_o_man-1:0] man_q, man_d;
  logic [width_i-1:0]     buf_q [K];

  logic                   inBeat;
  logic                   outBeat;
  logic                   loadOut;
  logic [width_i-1:0]     inAbs;
  logic [width_i-1:0]     curElem;
  logic [width_i-1:0]     curAbs;
  logic [width_o_exp-1:0] rndExp;
  logic [width_o_man-1:0] rndMan;
  logic [width_shift-1:0] blkScale;

  // Two's complement magnitude; the most negative value maps to 2^(w-1)
  // which still fits unsigned in w bits.
  function automatic logic [width_i-1:0] absVal(input logic [width_i-1:0] v);
    return v[width_i-1] ? (~v + width_i'(1)) : v;
  endfunction

  assign o_ready = (state_q == ST_LOAD) && i_rst_n;
  assign o_valid = valid_q;
  assign o_sign  = sign_q;
  assign o_exp   = exp_q;
  assign o_man   = man_q;
  assign o_scale = scale_q;
  assign o_last  = last_q;

  assign inBeat  = i_valid && o_ready;
  assign outBeat = valid_q && i_ready;
  assign loadOut = (state_q == ST_EMIT) && (cnt_q < CntW'(K)) && (!valid_q || i_ready);
  assign inAbs   = absVal(i_num);
  assign curElem = buf_q[cnt_q[IdxW-1:0]];
  assign curAbs  = absVal(curElem);

  fp_rnd_rne #(
    .width_i    (width_i),
    .width_shift(width_shift),
    .width_o_exp(width_o_exp),
    .width_o_man(width_o_man),
    .EMAX_ELEM  (EMAX_ELEM)
  ) u_rnd (
    .i_num  (curAbs),
    .i_shift(scale_q),
    .o_exp  (rndExp),
    .o_man  (rndMan)
  );

  // Block exponent: leading-one position of the max magnitude minus the
  // element format's top exponent, floored at zero (also covers all-zero).
  always_comb begin
    int p;
    p = lzd_pos(32'(maxAbs_q));
    blkScale = (p > EMAX_ELEM) ? width_shift'(p - EMAX_ELEM) : '0;
  end

  // Next-state and datapath control for the LOAD -> SCALE -> EMIT sequence.
  // In EMIT the output register refills whenever it is empty or being taken,
  // so a steady i_ready gives one element per cycle with no skips or repeats.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    maxAbs_d = maxAbs_q;
    scale_d  = scale_q;
    valid_d  = valid_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    man_d    = man_q;
    last_d   = last_q;
    unique case (state_q)
      ST_LOAD: begin
        if (inBeat) begin
          cnt_d = cnt_q + CntW'(1);
          if (inAbs > maxAbs_q) maxAbs_d = inAbs;
          if (cnt_q == CntW'(K - 1)) state_d = ST_SCALE;
        end
      end
      ST_SCALE: begin
        scale_d  = blkScale;
        cnt_d    = '0;
        maxAbs_d = '0;
        state_d  = ST_EMIT;
      end
      ST_EMIT: begin
        if (outBeat && last_q) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end else if (loadOut) begin
          valid_d = 1'b1;
          sign_d  = curElem[width_i-1] && ((rndExp != '0) || (rndMan != '0));
          exp_d   = rndExp;
          man_d   = rndMan;
          last_d  = (cnt_q == CntW'(K - 1));
          cnt_d   = cnt_q + CntW'(1);
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Control and output registers; reset drops any partial block.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_LOAD;
      cnt_q    <= '0;
      maxAbs_q <= '0;
      scale_q  <= '0;
      valid_q  <= 1'b0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      man_q    <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      maxAbs_q <= maxAbs_d;
      scale_q  <= scale_d;
      valid_q  <= valid_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      man_q    <= man_d;
      last_q   <= last_d;
    end
  end

  // Element buffer, written only on accepted input beats.
  always_ff @(posedge i_clk) begin
    if (inBeat) buf_q[cnt_q[IdxW-1:0]] <= i_num;
  end

endmodule

// File: tb/tb_mx_blk_quant_seq.sv
// Self-checking bench for mx_blk_quant_seq with the default E2M1 parameters.
module tb_mx_blk_quant_seq;

  localparam int K = 32;

  typedef struct {
    int s;
    int e;
    int m;
    int sc;
    int last;
    int idx;
  } expRec_t;

  typedef struct {
    int a;
    int b;
    int eScale;
    int sA;
    int eA;
    int mA;
    int sB;
    int eB;
    int mB;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_num;
  logic       o_valid;
  logic       i_ready;
  logic       o_sign;
  logic [1:0] o_exp;
  logic [0:0] o_man;
  logic [7:0] o_scale;
  logic       o_last;

  int      checks = 0;
  int      failures = 0;
  expRec_t expQ[$];
  int      inQ[$];
  int      curBlk[$];
  bit      tabActive = 0;
  vec_t    tab;
  vec_t    vecs[4];

  mx_blk_quant_seq dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_num  (i_num),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_sign (o_sign),
    .o_exp  (o_exp),
    .o_man  (o_man),
    .o_scale(o_scale),
    .o_last (o_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Shared exponent: floor(log2(maxabs)) minus 2, never below zero.
  function automatic int refScale(input int mx);
    int p;
    p = -1;
    for (int b = 0; b < 16; b++) if (mx >= (1 << b)) p = b;
    return (p > 2) ? p - 2 : 0;
  endfunction

  // Nearest E2M1 value to |x|/2^sc, ties to even code, no negative zero.
  task automatic refElem(input int x, input int sc, output int s, output int e, output int m);
    real v, best, cv, d;
    int  bestCode, ce, cm;
    v = (x < 0) ? real'(-x) : real'(x);
    for (int i = 0; i < sc; i++) v = v / 2.0;
    best = -1.0;
    bestCode = 0;
    for (int c = 0; c < 8; c++) begin
      ce = c >> 1;
      cm = c & 1;
      if (ce == 0) cv = 0.5 * real'(cm);
      else cv = (1.0 + 0.5 * real'(cm)) * real'(1 << (ce - 1));
      d = (cv > v) ? cv - v : v - cv;
      if (best < 0.0 || d < best || (d == best && (c % 2) == 0)) begin
        best = d;
        bestCode = c;
      end
    end
    e = bestCode >> 1;
    m = bestCode & 1;
    s = (x < 0 && bestCode != 0) ? 1 : 0;
  endtask

  task automatic modelBlock();
    int      mx, sc, a;
    expRec_t r;
    mx = 0;
    foreach (curBlk[j]) begin
      a = (curBlk[j] < 0) ? -curBlk[j] : curBlk[j];
      if (a > mx) mx = a;
    end
    sc = refScale(mx);
    for (int j = 0; j < K; j++) begin
      refElem(curBlk[j], sc, r.s, r.e, r.m);
      r.sc = sc;
      r.last = (j == K - 1) ? 1 : 0;
      r.idx = j;
      expQ.push_back(r);
    end
    curBlk.delete();
  endtask

  task automatic checkOutput(input expRec_t r);
    checkVal("sign", o_sign, r.s);
    checkVal("exp", o_exp, r.e);
    checkVal("man", o_man, r.m);
    checkVal("scale", o_scale, r.sc);
    checkVal("last", o_last, r.last);
    if (tabActive) begin
      checkVal("tabScale", o_scale, tab.eScale);
      checkVal("tabSign", o_sign, (r.idx % 2 == 0) ? tab.sA : tab.sB);
      checkVal("tabExp", o_exp, (r.idx % 2 == 0) ? tab.eA : tab.eB);
      checkVal("tabMan", o_man, (r.idx % 2 == 0) ? tab.mA : tab.mB);
    end
  endtask

  // Drives queued elements with random valid gaps and consumes outputs with
  // random (or toggling, readyPct<0) ready; optionally stalls 20 cycles once
  // stallAt outputs have been taken.
  task automatic applyStimulus(input int validPct, input int readyPct, input int stallAt,
                               input int budget);
    int cyc, stallLeft, outCount;
    bit stallDone, firstStall;
    int snap[5];
    cyc = 0;
    stallLeft = 0;
    outCount = 0;
    stallDone = 0;
    firstStall = 0;
    while ((inQ.size() != 0 || expQ.size() != 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (stallAt >= 0 && !stallDone && o_valid && outCount == stallAt) begin
        stallLeft = 20;
        stallDone = 1;
        firstStall = 1;
        snap[0] = o_sign; snap[1] = o_exp; snap[2] = o_man; snap[3] = o_scale; snap[4] = o_last;
      end
      if (stallLeft > 0) begin
        if (!firstStall) begin
          checkVal("stallValid", o_valid, 1);
          checkVal("stallSign", o_sign, snap[0]);
          checkVal("stallExp", o_exp, snap[1]);
          checkVal("stallMan", o_man, snap[2]);
          checkVal("stallScale", o_scale, snap[3]);
          checkVal("stallLast", o_last, snap[4]);
        end
        checkVal("stallReady", o_ready, 0);
        firstStall = 0;
        i_ready = 1'b0;
        stallLeft--;
      end else if (readyPct < 0) begin
        i_ready = cyc[0];
      end else begin
        i_ready = ($urandom_range(99) < readyPct);
      end
      if (inQ.size() != 0 && $urandom_range(99) < validPct) begin
        i_valid = 1'b1;
        i_num = 8'(inQ[0]);
      end else if (!o_ready) begin
        i_valid = 1'($urandom_range(1));
        i_num = 8'($urandom_range(255));
      end else begin
        i_valid = 1'b0;
        i_num = 8'($urandom_range(255));
      end
      if (o_valid && i_ready) begin
        if (expQ.size() == 0) begin
          checkVal("extraOutput", 1, 0);
        end else begin
          checkOutput(expQ.pop_front());
          outCount++;
        end
      end
      if (i_valid && o_ready) begin
        curBlk.push_back(inQ.pop_front());
        if (curBlk.size() == K) modelBlock();
      end
    end
    if (inQ.size() != 0 || expQ.size() != 0) begin
      checkVal("timeoutPending", inQ.size() + expQ.size(), 0);
      inQ.delete();
      expQ.delete();
    end
    @(negedge clk);
    i_valid = 1'b0;
    checkVal("validDropsAfter", o_valid, 0);
    checkVal("readyBackAfter", o_ready, 1);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkVal("rstReady", o_ready, 0);
    checkVal("rstValid", o_valid, 0);
    checkVal("rstSign", o_sign, 0);
    checkVal("rstExp", o_exp, 0);
    checkVal("rstMan", o_man, 0);
    checkVal("rstScale", o_scale, 0);
    checkVal("rstLast", o_last, 0);
    rst_n = 1'b1;
    #1;
    checkVal("readyAfterRst", o_ready, 1);
    curBlk.delete();
    expQ.delete();
    inQ.delete();
  endtask

  function automatic int randElem(input int maxBits);
    int bits;
    bits = $urandom_range(1, maxBits);
    return int'($urandom_range(0, (1 << bits) - 1)) - (1 << (bits - 1));
  endfunction

  // Ten accepted LOAD beats, then reset: that partial block must vanish.
  task automatic abortPartialBlock();
    for (int k = 0; k < 10; k++) inQ.push_back(randElem(8));
    applyStimulus(100, 100, -1, 200);
    checkVal("partialNoValid", o_valid, 0);
    doReset();
  endtask

  initial begin
    rst_n = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_num = '0;
    doReset();

    vecs[0] = '{12, 12, 1, 0, 3, 1, 0, 3, 1};
    vecs[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2] = '{-128, 1, 5, 1, 3, 0, 0, 0, 0};
    vecs[3] = '{5, 5, 0, 0, 3, 0, 0, 3, 0};
    for (int t = 0; t < 4; t++) begin
      if (t == 3) abortPartialBlock();
      for (int k = 0; k < K; k++) inQ.push_back((k % 2 == 0) ? vecs[t].a : vecs[t].b);
      tab = vecs[t];
      tabActive = 1;
      applyStimulus(100, 100, -1, 500);
      tabActive = 0;
    end

    for (int k = 0; k < K; k++) inQ.push_back(randElem(8));
    applyStimulus(100, 100, 7, 500);

    for (int k = 0; k < K; k++) inQ.push_back(randElem(6));
    applyStimulus(100, -1, -1, 500);

    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < K; k++) inQ.push_back(randElem(1 + b));
      applyStimulus(60, 60, -1, 2000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
